// File: rtl/vx_lsu_coalescer.sv
// LSU-to-dcache request coalescer: merges lanes sharing a memory line into one
// line request, tracks loads in a pending table and reassembles per-lane responses.
module vx_lsu_coalescer #(
   parameter int NUM_LANES  = 4,
   parameter int WORD_SIZE  = 4,
   parameter int LINE_SIZE  = 16,
   parameter int QUEUE_SIZE = 8,
   parameter int TAG_WIDTH  = 8,
   localparam int WORDS   = LINE_SIZE / WORD_SIZE,
   localparam int OFS_W   = $clog2(WORDS),
   localparam int WADDR_W = 32 - $clog2(WORD_SIZE),
   localparam int LADDR_W = 32 - $clog2(LINE_SIZE),
   localparam int QIDX_W  = $clog2(QUEUE_SIZE),
   localparam int QTAG_W  = QIDX_W + NUM_LANES,
   localparam int WORD_W  = 8 * WORD_SIZE
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_req_valid,
   output logic                          in_req_ready,
   input  logic                          in_req_rw,
   input  logic [NUM_LANES-1:0]          in_req_mask,
   input  logic [NUM_LANES*WADDR_W-1:0]  in_req_addr,
   input  logic [NUM_LANES*WORD_SIZE-1:0] in_req_byteen,
   input  logic [NUM_LANES*WORD_W-1:0]   in_req_data,
   input  logic [TAG_WIDTH-1:0]          in_req_tag,
   output logic                          mem_req_valid,
   input  logic                          mem_req_ready,
   output logic                          mem_req_rw,
   output logic [LADDR_W-1:0]            mem_req_addr,
   output logic [LINE_SIZE-1:0]          mem_req_byteen,
   output logic [8*LINE_SIZE-1:0]        mem_req_data,
   output logic [QTAG_W-1:0]             mem_req_tag,
   input  logic                          mem_rsp_valid,
   output logic                          mem_rsp_ready,
   input  logic [8*LINE_SIZE-1:0]        mem_rsp_data,
   input  logic [QTAG_W-1:0]             mem_rsp_tag,
   output logic                          in_rsp_valid,
   input  logic                          in_rsp_ready,
   output logic [NUM_LANES-1:0]          in_rsp_mask,
   output logic [NUM_LANES*WORD_W-1:0]   in_rsp_data,
   output logic [TAG_WIDTH-1:0]          in_rsp_tag
);

   localparam int LIDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

   typedef enum logic {IDLE, ISSUE} state_t;
   state_t state, state_next;

   logic                  req_rw;
   logic [WADDR_W-1:0]    req_addr   [NUM_LANES];
   logic [WORD_SIZE-1:0]  req_byteen [NUM_LANES];
   logic [WORD_W-1:0]     req_data   [NUM_LANES];
   logic [QIDX_W-1:0]     req_qidx;
   logic [NUM_LANES-1:0]  pend, group, pend_left;
   logic [LIDX_W-1:0]     leader;
   logic [LADDR_W-1:0]    leader_line;

   logic [QUEUE_SIZE-1:0] q_valid;
   logic [TAG_WIDTH-1:0]  q_tag  [QUEUE_SIZE];
   logic [NUM_LANES-1:0]  q_mask [QUEUE_SIZE];
   logic [NUM_LANES-1:0]  q_rem  [QUEUE_SIZE];
   logic [OFS_W-1:0]      q_ofs  [QUEUE_SIZE][NUM_LANES];
   logic [WORD_W-1:0]     q_buf  [QUEUE_SIZE][NUM_LANES];

   logic [QIDX_W-1:0]     alloc_idx, rsp_idx;
   logic                  full, in_fire, alloc, mem_fire;
   logic                  rsp_fire, rsp_hit, done;
   logic [NUM_LANES-1:0]  rsp_grp, rsp_take, rem_next;
   logic [WORD_W-1:0]     buf_next [NUM_LANES];
   logic [NUM_LANES*WORD_W-1:0] buf_flat;

   // lowest free entry; full is judged on the table as it stands this cycle
   always_comb begin
      alloc_idx = '0;
      full      = 1'b1;
      for (int q = QUEUE_SIZE - 1; q >= 0; q--) begin
         if (!q_valid[q]) begin
            alloc_idx = QIDX_W'(q);
            full      = 1'b0;
         end
      end
   end

   assign in_req_ready = (state == IDLE) && (in_req_rw || !full);
   assign in_fire      = in_req_valid && in_req_ready;
   assign alloc        = in_fire && !in_req_rw && (|in_req_mask);

   always_comb begin
      leader = '0;
      group  = '0;
      for (int i = NUM_LANES - 1; i >= 0; i--) begin
         if (pend[i]) leader = LIDX_W'(i);
      end
      leader_line = req_addr[leader][WADDR_W-1:OFS_W];
      for (int i = 0; i < NUM_LANES; i++) begin
         group[i] = pend[i] && (req_addr[i][WADDR_W-1:OFS_W] == leader_line);
      end
   end

   // ascending lane order lets the highest lane win an overlapping store byte
   always_comb begin
      mem_req_valid  = (state == ISSUE);
      mem_req_rw     = 1'b0;
      mem_req_addr   = '0;
      mem_req_byteen = '0;
      mem_req_data   = '0;
      mem_req_tag    = '0;
      if (state == ISSUE) begin
         mem_req_rw   = req_rw;
         mem_req_addr = leader_line;
         mem_req_tag  = {req_qidx, group};
         if (req_rw) begin
            for (int i = 0; i < NUM_LANES; i++) begin
               for (int b = 0; b < WORD_SIZE; b++) begin
                  if (group[i] && req_byteen[i][b]) begin
                     mem_req_byteen[int'(req_addr[i][OFS_W-1:0]) * WORD_SIZE + b] = 1'b1;
                     mem_req_data[(int'(req_addr[i][OFS_W-1:0]) * WORD_SIZE + b) * 8 +: 8] =
                        req_data[i][b*8 +: 8];
                  end
               end
            end
         end else begin
            mem_req_byteen = '1;
         end
      end
   end

   assign mem_fire  = mem_req_valid && mem_req_ready;
   assign pend_left = pend & ~group;

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_fire && (|in_req_mask)) state_next = ISSUE;
         ISSUE:   if (mem_fire && (pend_left == '0)) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         pend  <= '0;
      end else begin
         state <= state_next;
         if (in_fire)       pend <= in_req_mask;
         else if (mem_fire) pend <= pend_left;
      end
   end

   always_ff @(posedge clk) begin
      if (in_fire) begin
         req_rw   <= in_req_rw;
         req_qidx <= alloc_idx;
         for (int i = 0; i < NUM_LANES; i++) begin
            req_addr[i]   <= in_req_addr[i*WADDR_W +: WADDR_W];
            req_byteen[i] <= in_req_byteen[i*WORD_SIZE +: WORD_SIZE];
            req_data[i]   <= in_req_data[i*WORD_W +: WORD_W];
         end
      end
   end

   assign mem_rsp_ready = !(in_rsp_valid && !in_rsp_ready);
   assign rsp_idx       = mem_rsp_tag[QTAG_W-1:NUM_LANES];
   assign rsp_grp       = mem_rsp_tag[NUM_LANES-1:0];
   assign rsp_fire      = mem_rsp_valid && mem_rsp_ready;
   assign rsp_hit       = rsp_fire && q_valid[rsp_idx];
   assign rsp_take      = rsp_grp & q_rem[rsp_idx];
   assign rem_next      = q_rem[rsp_idx] & ~rsp_grp;
   assign done          = rsp_hit && (rem_next == '0);

   always_comb begin
      buf_flat = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         buf_next[i] = rsp_take[i] ? mem_rsp_data[int'(q_ofs[rsp_idx][i]) * WORD_W +: WORD_W]
                                   : q_buf[rsp_idx][i];
         buf_flat[i*WORD_W +: WORD_W] = buf_next[i];
      end
   end

   // responses to entries discarded by reset find q_valid clear and are dropped
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q_valid <= '0;
      end else begin
         if (done)  q_valid[rsp_idx]   <= 1'b0;
         if (alloc) q_valid[alloc_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rsp_hit) begin
         q_rem[rsp_idx] <= rem_next;
         for (int i = 0; i < NUM_LANES; i++) q_buf[rsp_idx][i] <= buf_next[i];
      end
      if (alloc) begin
         q_tag[alloc_idx]  <= in_req_tag;
         q_mask[alloc_idx] <= in_req_mask;
         q_rem[alloc_idx]  <= in_req_mask;
         for (int i = 0; i < NUM_LANES; i++) begin
            q_ofs[alloc_idx][i] <= in_req_addr[i*WADDR_W +: OFS_W];
            q_buf[alloc_idx][i] <= '0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         in_rsp_valid <= 1'b0;
         in_rsp_mask  <= '0;
         in_rsp_data  <= '0;
         in_rsp_tag   <= '0;
      end else if (done) begin
         in_rsp_valid <= 1'b1;
         in_rsp_mask  <= q_mask[rsp_idx];
         in_rsp_data  <= buf_flat;
         in_rsp_tag   <= q_tag[rsp_idx];
      end else if (in_rsp_ready) begin
         in_rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_vx_lsu_coalescer.sv
// Directed bench for vx_lsu_coalescer with hand-computed expected values.
module tb_vx_lsu_coalescer;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         in_req_valid = 1'b0;
   logic         in_req_ready;
   logic         in_req_rw = 1'b0;
   logic [3:0]   in_req_mask = '0;
   logic [119:0] in_req_addr = '0;
   logic [15:0]  in_req_byteen = '0;
   logic [127:0] in_req_data = '0;
   logic [7:0]   in_req_tag = '0;
   logic         mem_req_valid;
   logic         mem_req_ready = 1'b1;
   logic         mem_req_rw;
   logic [27:0]  mem_req_addr;
   logic [15:0]  mem_req_byteen;
   logic [127:0] mem_req_data;
   logic [6:0]   mem_req_tag;
   logic         mem_rsp_valid = 1'b0;
   logic         mem_rsp_ready;
   logic [127:0] mem_rsp_data = '0;
   logic [6:0]   mem_rsp_tag = '0;
   logic         in_rsp_valid;
   logic         in_rsp_ready = 1'b1;
   logic [3:0]   in_rsp_mask;
   logic [127:0] in_rsp_data;
   logic [7:0]   in_rsp_tag;

   int n_checks = 0;
   int n_pass   = 0;

   vx_lsu_coalescer dut (
      .clk(clk), .reset(reset),
      .in_req_valid(in_req_valid), .in_req_ready(in_req_ready), .in_req_rw(in_req_rw),
      .in_req_mask(in_req_mask), .in_req_addr(in_req_addr), .in_req_byteen(in_req_byteen),
      .in_req_data(in_req_data), .in_req_tag(in_req_tag),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
      .mem_req_addr(mem_req_addr), .mem_req_byteen(mem_req_byteen),
      .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
      .mem_rsp_data(mem_rsp_data), .mem_rsp_tag(mem_rsp_tag),
      .in_rsp_valid(in_rsp_valid), .in_rsp_ready(in_rsp_ready), .in_rsp_mask(in_rsp_mask),
      .in_rsp_data(in_rsp_data), .in_rsp_tag(in_rsp_tag)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, got, want);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic rw, input logic [3:0] mask,
                          input logic [29:0] a0, input logic [29:0] a1,
                          input logic [29:0] a2, input logic [29:0] a3,
                          input logic [3:0] be,
                          input logic [31:0] d0, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] d3,
                          input logic [7:0] tag);
      in_req_valid  = 1'b1;
      in_req_rw     = rw;
      in_req_mask   = mask;
      in_req_addr   = {a3, a2, a1, a0};
      in_req_byteen = {be, be, be, be};
      in_req_data   = {d3, d2, d1, d0};
      in_req_tag    = tag;
   endtask

   // waits (bounded) for acceptance, clocks the request in, then drops valid
   task automatic fire_req(input string name);
      int n = 0;
      #1;
      while (!in_req_ready && n < 20) begin
         tick();
         n++;
      end
      check(name, in_req_ready, 1'b1);
      tick();
      in_req_valid = 1'b0;
   endtask

   task automatic send_rsp(input logic [6:0] tag, input logic [127:0] data);
      mem_rsp_valid = 1'b1;
      mem_rsp_tag   = tag;
      mem_rsp_data  = data;
      tick();
      mem_rsp_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // reset values
      #12;
      check("rst_in_req_ready", in_req_ready, 1'b1);
      check("rst_mem_req_valid", mem_req_valid, 1'b0);
      check("rst_mem_rsp_ready", mem_rsp_ready, 1'b1);
      check("rst_in_rsp_valid", in_rsp_valid, 1'b0);
      check("rst_mem_req_byteen", mem_req_byteen, 16'h0);
      check("rst_in_rsp_data", in_rsp_data, 128'h0);
      tick();
      reset = 1'b1;
      tick();

      // 1: four lanes in one line
      set_req(1'b0, 4'hF, 30'h40, 30'h41, 30'h42, 30'h43, 4'hF, 0, 0, 0, 0, 8'h11);
      fire_req("t1_accept");
      check("t1_mreq_valid", mem_req_valid, 1'b1);
      check("t1_mreq_addr", mem_req_addr, 28'h10);
      check("t1_mreq_byteen", mem_req_byteen, 16'hFFFF);
      check("t1_mreq_tag", mem_req_tag, 7'h0F);
      check("t1_mreq_rw", mem_req_rw, 1'b0);
      tick();
      check("t1_single_mreq", mem_req_valid, 1'b0);
      check("t1_ready_back", in_req_ready, 1'b1);
      send_rsp(7'h0F, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
      check("t1_rsp_valid", in_rsp_valid, 1'b1);
      check("t1_rsp_mask", in_rsp_mask, 4'hF);
      check("t1_rsp_data", in_rsp_data, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
      check("t1_rsp_tag", in_rsp_tag, 8'h11);
      tick();
      check("t1_rsp_drop", in_rsp_valid, 1'b0);

      // 2: two lines, responses out of order
      set_req(1'b0, 4'hF, 30'h40, 30'h80, 30'h41, 30'h81, 4'hF, 0, 0, 0, 0, 8'h22);
      fire_req("t2_accept");
      check("t2_g0_addr", mem_req_addr, 28'h10);
      check("t2_g0_tag", mem_req_tag, 7'h05);
      tick();
      check("t2_g1_valid", mem_req_valid, 1'b1);
      check("t2_g1_addr", mem_req_addr, 28'h20);
      check("t2_g1_tag", mem_req_tag, 7'h0A);
      check("t2_busy_ready", in_req_ready, 1'b0);
      tick();
      check("t2_done_valid", mem_req_valid, 1'b0);
      check("t2_ready_back", in_req_ready, 1'b1);
      send_rsp(7'h0A, {32'hDEAD0003, 32'hDEAD0002, 32'hB1B1B1B1, 32'hB0B0B0B0});
      check("t2_no_early_rsp", in_rsp_valid, 1'b0);
      send_rsp(7'h05, {32'hDEAD0013, 32'hDEAD0012, 32'hA1A1A1A1, 32'hA0A0A0A0});
      check("t2_rsp_valid", in_rsp_valid, 1'b1);
      check("t2_rsp_mask", in_rsp_mask, 4'hF);
      check("t2_rsp_data", in_rsp_data, {32'hB1B1B1B1, 32'hA1A1A1A1, 32'hB0B0B0B0, 32'hA0A0A0A0});
      check("t2_rsp_tag", in_rsp_tag, 8'h22);
      tick();
      check("t2_rsp_drop", in_rsp_valid, 1'b0);

      // 3: store with overlapping lanes; masked lanes must not join
      set_req(1'b1, 4'b0101, 30'h40, 30'h40, 30'h40, 30'h42, 4'hF,
              32'hAAAAAAAA, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hDDDDDDDD, 8'h33);
      fire_req("t3_accept");
      check("t3_mreq_rw", mem_req_rw, 1'b1);
      check("t3_mreq_addr", mem_req_addr, 28'h10);
      check("t3_mreq_byteen", mem_req_byteen, 16'h000F);
      check("t3_mreq_data", mem_req_data, 128'hBBBBBBBB);
      check("t3_mreq_group", mem_req_tag[3:0], 4'b0101);
      tick();
      check("t3_single_mreq", mem_req_valid, 1'b0);
      tick();
      check("t3_no_rsp", in_rsp_valid, 1'b0);

      // 4: fill the queue
      for (int k = 0; k < 8; k++) begin
         set_req(1'b0, 4'b0001, 30'h100 + 30'(k), 0, 0, 0, 4'hF, 0, 0, 0, 0, 8'h30 + 8'(k));
         fire_req("t4_accept");
         check("t4_qidx", mem_req_tag, {3'(k), 4'b0001});
         tick();
      end
      set_req(1'b0, 4'b0001, 30'h108, 0, 0, 0, 4'hF, 0, 0, 0, 0, 8'h38);
      #1;
      check("t4_full_blocks_load", in_req_ready, 1'b0);
      in_req_rw = 1'b1;
      #1;
      check("t4_store_when_full", in_req_ready, 1'b1);
      tick();
      in_req_valid = 1'b0;
      check("t4_store_mreq", mem_req_rw, 1'b1);
      tick();
      check("t4_store_done", mem_req_valid, 1'b0);
      set_req(1'b0, 4'b0001, 30'h10B, 0, 0, 0, 4'hF, 0, 0, 0, 0, 8'h3F);
      mem_rsp_valid = 1'b1;
      mem_rsp_tag   = 7'h31;
      mem_rsp_data  = {32'hD3D3D3D3, 32'h11111111, 32'h22222222, 32'h33333333};
      #1;
      check("t4_still_full", in_req_ready, 1'b0);
      tick();
      mem_rsp_valid = 1'b0;
      #1;
      check("t4_rsp_valid", in_rsp_valid, 1'b1);
      check("t4_rsp_tag", in_rsp_tag, 8'h33);
      check("t4_rsp_data", in_rsp_data, 128'hD3D3D3D3);
      check("t4_ready_after_free", in_req_ready, 1'b1);
      tick();
      in_req_valid = 1'b0;
      check("t4_reuse_entry", mem_req_tag, 7'h31);
      check("t4_reuse_addr", mem_req_addr, 28'h42);
      tick();
      check("t4_reuse_done", mem_req_valid, 1'b0);

      // 5: upstream backpressure
      in_rsp_ready = 1'b0;
      send_rsp(7'h01, {32'h0, 32'h0, 32'h0, 32'hE0E0E0E0});
      mem_rsp_valid = 1'b1;
      mem_rsp_tag   = 7'h11;
      mem_rsp_data  = {32'h0, 32'h0, 32'hE1E1E1E1, 32'h0};
      #1;
      for (int c = 0; c < 5; c++) begin
         check("t5_hold_valid", in_rsp_valid, 1'b1);
         check("t5_hold_tag", in_rsp_tag, 8'h30);
         check("t5_hold_data", in_rsp_data, 128'hE0E0E0E0);
         check("t5_stall_ready", mem_rsp_ready, 1'b0);
         tick();
      end
      in_rsp_ready = 1'b1;
      #1;
      check("t5_release_ready", mem_rsp_ready, 1'b1);
      tick();
      mem_rsp_valid = 1'b0;
      check("t5_next_valid", in_rsp_valid, 1'b1);
      check("t5_next_tag", in_rsp_tag, 8'h31);
      check("t5_next_data", in_rsp_data, 128'hE1E1E1E1);
      tick();
      check("t5_no_dup", in_rsp_valid, 1'b0);

      // 6: reset in the middle of an issue
      in_rsp_ready = 1'b0;
      send_rsp(7'h21, {32'h0, 32'hF2F2F2F2, 32'h0, 32'h0});
      check("t6_rsp_pending", in_rsp_valid, 1'b1);
      check("t6_rsp_tag", in_rsp_tag, 8'h32);
      mem_req_ready = 1'b0;
      set_req(1'b0, 4'b0011, 30'h200, 30'h300, 0, 0, 4'hF, 0, 0, 0, 0, 8'h40);
      fire_req("t6_accept");
      check("t6_mreq_valid", mem_req_valid, 1'b1);
      check("t6_mreq_tag", mem_req_tag, 7'h01);
      tick();
      check("t6_mreq_stable", mem_req_tag, 7'h01);
      #2;
      reset = 1'b0;
      #1;
      check("t6_rst_mreq_valid", mem_req_valid, 1'b0);
      check("t6_rst_rsp_valid", in_rsp_valid, 1'b0);
      check("t6_rst_req_ready", in_req_ready, 1'b1);
      tick();
      reset = 1'b1;
      mem_req_ready = 1'b1;
      in_rsp_ready  = 1'b1;
      tick();
      send_rsp(7'h41, {32'h0, 32'h0, 32'h0, 32'h99999999});
      check("t6_stale_ignored", in_rsp_valid, 1'b0);
      for (int k = 0; k < 8; k++) begin
         set_req(1'b0, 4'b0001, 30'h400 + 30'(k), 0, 0, 0, 4'hF, 0, 0, 0, 0, 8'h50 + 8'(k));
         fire_req("t6_accept8");
         check("t6_qidx", mem_req_tag, {3'(k), 4'b0001});
         tick();
      end
      set_req(1'b0, 4'b0001, 30'h408, 0, 0, 0, 4'hF, 0, 0, 0, 0, 8'h58);
      #1;
      check("t6_full_again", in_req_ready, 1'b0);
      in_req_valid = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
